// File: rtl/csr_file_pkg.sv
`default_nettype none
// =============================================================================
// csr_file_pkg : CSR addresses, mstatus bit positions, mcause/mtvec types. Rev 1.0
// =============================================================================
package csr_file_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MISA      = 12'h301,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MTVAL     = 12'h343,
        CSR_MIP       = 12'h344,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_CYCLE     = 12'hC00,
        CSR_INSTRET   = 12'hC02,
        CSR_CYCLEH    = 12'hC80,
        CSR_INSTRETH  = 12'hC82,
        CSR_MVENDORID = 12'hF11,
        CSR_MARCHID   = 12'hF12,
        CSR_MIMPID    = 12'hF13,
        CSR_MHARTID   = 12'hF14
    } csr_addr_t;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Only the external, timer and software interrupt lines exist.
    localparam logic [WORD_W-1:0] MIP_MASK = 32'h0000_0888;

    typedef struct packed {
        logic        irq;
        logic [25:0] pad;
        logic [4:0]  code;
    } mcause_t;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'd0,
        MTVEC_VECTORED = 2'd1
    } mtvec_mode_t;

    function automatic logic is_counter_addr(input logic [11:0] addr);
        return (addr == CSR_MCYCLE)  || (addr == CSR_MINSTRET)  ||
               (addr == CSR_MCYCLEH) || (addr == CSR_MINSTRETH) ||
               (addr == CSR_CYCLE)   || (addr == CSR_INSTRET)   ||
               (addr == CSR_CYCLEH)  || (addr == CSR_INSTRETH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_file_if.sv
`default_nettype none
// =============================================================================
// csr_if : CSR access, trap/retire events and fetch-side outputs. Rev 1.0
// =============================================================================
interface csr_if;
    import csr_file_pkg::*;

    logic              csr_write;
    logic [11:0]       csr_waddr;
    logic [WORD_W-1:0] csr_wdata;
    logic [11:0]       csr_raddr;
    logic [WORD_W-1:0] csr_rdata;
    logic              csr_illegal;
    logic              instr_retire;
    logic              trap_valid;
    logic              trap_is_irq;
    logic [4:0]        trap_cause;
    logic [WORD_W-1:0] trap_pc;
    logic [WORD_W-1:0] trap_tval;
    logic              mret;
    logic [WORD_W-1:0] trap_vector;
    logic [WORD_W-1:0] mepc_out;
    logic              irq_ext;
    logic              irq_tmr;
    logic              irq_sw;
    logic              irq_pending;

    modport master (
        output csr_write, csr_waddr, csr_wdata, csr_raddr,
        output instr_retire, trap_valid, trap_is_irq, trap_cause, trap_pc, trap_tval, mret,
        output irq_ext, irq_tmr, irq_sw,
        input  csr_rdata, csr_illegal, trap_vector, mepc_out, irq_pending
    );

    modport slave (
        input  csr_write, csr_waddr, csr_wdata, csr_raddr,
        input  instr_retire, trap_valid, trap_is_irq, trap_cause, trap_pc, trap_tval, mret,
        input  irq_ext, irq_tmr, irq_sw,
        output csr_rdata, csr_illegal, trap_vector, mepc_out, irq_pending
    );

endinterface
`default_nettype wire

// File: rtl/csr_file_counter64.sv
`default_nettype none
// =============================================================================
// csr_counter64 : 64-bit free-running counter with per-half overwrite. Rev 1.0
// =============================================================================
module csr_counter64
    import csr_file_pkg::*;
(
    input  wire logic              CLK,
    input  wire logic              nRST,
    input  wire logic              inc,
    input  wire logic              wr_lo,
    input  wire logic              wr_hi,
    input  wire logic [WORD_W-1:0] wdata,
    output      logic [63:0]       count
);

    logic [63:0] cnt_q, cnt_d;

    // A write to either half owns the cycle: the whole counter skips its increment.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) cnt_d[31:0]  = wdata;
            if (wr_hi) cnt_d[63:32] = wdata;
        end else if (inc) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// =============================================================================
// csr_file : machine-mode CSR file for the RV32 core; CSR_COUNTERS_EN adds
//            mcycle/minstret. Rev 1.0
// =============================================================================
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [WORD_W-1:0] HART_ID     = '0,
    parameter logic [WORD_W-1:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [WORD_W-1:0] MISA_VAL    = 32'h4000_0100
) (
    input wire logic CLK,
    input wire logic nRST,
    csr_if.slave     bus
);

    logic              mstatus_mie_q,  mstatus_mie_d;
    logic              mstatus_mpie_q, mstatus_mpie_d;
    logic [WORD_W-1:0] mie_q,      mie_d;
    logic [WORD_W-1:0] mtvec_q,    mtvec_d;
    logic [WORD_W-1:0] mscratch_q, mscratch_d;
    logic [WORD_W-1:0] mepc_q,     mepc_d;
    mcause_t           mcause_q,   mcause_d;
    logic [WORD_W-1:0] mtval_q,    mtval_d;

    logic [WORD_W-1:0] mip_val;
    logic [WORD_W-1:0] mstatus_rd;
    logic [WORD_W-1:0] rdata;
    logic              rd_ok;
    logic              wr_ok;
    logic              wr_en;
    logic              trap_state_busy;
    logic [WORD_W-1:0] vec_base;
    logic [63:0]       mcycle;
    logic [63:0]       minstret;

    assign mip_val = {20'b0, bus.irq_ext, 3'b0, bus.irq_tmr, 3'b0, bus.irq_sw, 3'b0};

    always_comb begin
        mstatus_rd               = '0;
        mstatus_rd[12:11]        = 2'b11;
        mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
    end

    // ---------------------------------------------------------------- counters
`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (1'b1),
        .wr_lo (wr_en && (bus.csr_waddr == CSR_MCYCLE)),
        .wr_hi (wr_en && (bus.csr_waddr == CSR_MCYCLEH)),
        .wdata (bus.csr_wdata),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (bus.instr_retire),
        .wr_lo (wr_en && (bus.csr_waddr == CSR_MINSTRET)),
        .wr_hi (wr_en && (bus.csr_waddr == CSR_MINSTRETH)),
        .wdata (bus.csr_wdata),
        .count (minstret)
    );
`else
    logic unused_retire;
    assign unused_retire = bus.instr_retire;
    assign mcycle        = '0;
    assign minstret      = '0;
`endif

    // ------------------------------------------------------------- read path
    always_comb begin
        rdata = '0;
        rd_ok = 1'b1;
        case (bus.csr_raddr)
            CSR_MSTATUS:                rdata = mstatus_rd;
            CSR_MISA:                   rdata = MISA_VAL;
            CSR_MIE:                    rdata = mie_q;
            CSR_MTVEC:                  rdata = mtvec_q;
            CSR_MSCRATCH:               rdata = mscratch_q;
            CSR_MEPC:                   rdata = mepc_q;
            CSR_MCAUSE:                 rdata = mcause_q;
            CSR_MTVAL:                  rdata = mtval_q;
            CSR_MIP:                    rdata = mip_val;
            CSR_MCYCLE,    CSR_CYCLE:   rdata = mcycle[31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:  rdata = mcycle[63:32];
            CSR_MINSTRET,  CSR_INSTRET: rdata = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[63:32];
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = '0;
            CSR_MHARTID:                rdata = HART_ID;
            default:                    rd_ok = 1'b0;
        endcase
    end

    assign bus.csr_rdata = rdata;

    // ----------------------------------------------------------- write decode
    always_comb begin
        wr_ok = 1'b0;
        case (bus.csr_waddr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL: wr_ok = 1'b1;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: wr_ok = 1'b1;
`endif
            default: wr_ok = 1'b0;
        endcase
`ifndef CSR_COUNTERS_EN
        // Absent counters are silently accepted and discarded.
        if (is_counter_addr(bus.csr_waddr)) wr_ok = 1'b1;
`endif
    end

    assign wr_en           = bus.csr_write && wr_ok;
    assign trap_state_busy = bus.trap_valid || bus.mret;
    assign bus.csr_illegal = !rd_ok ||
                             (bus.csr_write && (bus.csr_raddr == bus.csr_waddr) && !wr_ok);

    // ------------------------------------------------------------ next state
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (wr_en) begin
            case (bus.csr_waddr)
                CSR_MIE:      mie_d      = bus.csr_wdata & MIP_MASK;
                CSR_MSCRATCH: mscratch_d = bus.csr_wdata;
                CSR_MTVEC: begin
                    mtvec_d = {bus.csr_wdata[31:2],
                               (bus.csr_wdata[1:0] == MTVEC_VECTORED) ? MTVEC_VECTORED
                                                                      : MTVEC_DIRECT};
                end
                // Trap-state CSRs yield to a same-cycle trap or mret.
                CSR_MSTATUS: begin
                    if (!trap_state_busy) begin
                        mstatus_mie_d  = bus.csr_wdata[MSTATUS_MIE];
                        mstatus_mpie_d = bus.csr_wdata[MSTATUS_MPIE];
                    end
                end
                CSR_MEPC:   if (!trap_state_busy) mepc_d   = {bus.csr_wdata[31:2], 2'b00};
                CSR_MCAUSE: if (!trap_state_busy) mcause_d = mcause_t'(bus.csr_wdata);
                CSR_MTVAL:  if (!trap_state_busy) mtval_d  = bus.csr_wdata;
                default: ;
            endcase
        end

        if (bus.trap_valid) begin
            mepc_d         = {bus.trap_pc[31:2], 2'b00};
            mcause_d.irq   = bus.trap_is_irq;
            mcause_d.pad   = '0;
            mcause_d.code  = bus.trap_cause;
            mtval_d        = bus.trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (bus.mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    // ------------------------------------------------------- fetch-side outputs
    assign vec_base = {mtvec_q[31:2], 2'b00};

    always_comb begin
        bus.trap_vector = vec_base;
        if ((mtvec_mode_t'(mtvec_q[1:0]) == MTVEC_VECTORED) && bus.trap_is_irq) begin
            bus.trap_vector = vec_base + {25'b0, bus.trap_cause, 2'b00};
        end
    end

    assign bus.mepc_out    = mepc_q;
    assign bus.irq_pending = mstatus_mie_q && (|(mie_q & mip_val));

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// =============================================================================
// tb_csr_file : directed self-checking bench for csr_file (CSR_COUNTERS_EN aware). Rev 1.0
// =============================================================================
module tb_csr_file;

    localparam logic [31:0] P_HART  = 32'd5;
    localparam logic [31:0] P_MTVEC = 32'h0000_1001;
    localparam logic [31:0] P_MISA  = 32'h4000_0100;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    csr_if bus();

    csr_file #(
        .HART_ID     (P_HART),
        .MTVEC_RESET (P_MTVEC),
        .MISA_VAL    (P_MISA)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr);
        bus.csr_raddr = addr;
        #1;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        bus.csr_write = 1'b1;
        bus.csr_waddr = addr;
        bus.csr_wdata = data;
        tick();
        bus.csr_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.csr_write    = 1'b0;
        bus.csr_waddr    = '0;
        bus.csr_wdata    = '0;
        bus.csr_raddr    = '0;
        bus.instr_retire = 1'b0;
        bus.trap_valid   = 1'b0;
        bus.trap_is_irq  = 1'b0;
        bus.trap_cause   = '0;
        bus.trap_pc      = '0;
        bus.trap_tval    = '0;
        bus.mret         = 1'b0;
        bus.irq_ext      = 1'b0;
        bus.irq_tmr      = 1'b0;
        bus.irq_sw       = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_irq_pending", {31'b0, bus.irq_pending}, 32'h0);
        check("rst_mepc_out",    bus.mepc_out,    32'h0);
        check("rst_trap_vector", bus.trap_vector, 32'h0000_1000);
        nRST = 1'b1;

        // Identification and reset values
        rd(12'h301); check("misa", bus.csr_rdata, P_MISA);
        check("misa_legal", {31'b0, bus.csr_illegal}, 32'h0);
        rd(12'hF14); check("mhartid", bus.csr_rdata, P_HART);
        rd(12'h305); check("mtvec_rst", bus.csr_rdata, P_MTVEC);
        rd(12'h300); check("mstatus_rst", bus.csr_rdata, 32'h0000_1800);
        rd(12'h7C0); check("unimpl_rdata", bus.csr_rdata, 32'h0);
        check("unimpl_illegal", {31'b0, bus.csr_illegal}, 32'h1);

        // Read-before-write visibility
        bus.csr_raddr = 12'h340;
        bus.csr_write = 1'b1;
        bus.csr_waddr = 12'h340;
        bus.csr_wdata = 32'hDEAD_BEEF;
        #1;
        check("mscratch_same_cycle", bus.csr_rdata, 32'h0);
        tick();
        bus.csr_write = 1'b0;
        #1;
        check("mscratch_next", bus.csr_rdata, 32'hDEAD_BEEF);

        wr(12'h341, 32'h0000_1003);
        rd(12'h341); check("mepc_align", bus.csr_rdata, 32'h0000_1000);
        check("mepc_out", bus.mepc_out, 32'h0000_1000);

        // Write to a read-only CSR
        bus.csr_raddr = 12'h301;
        bus.csr_write = 1'b1;
        bus.csr_waddr = 12'h301;
        bus.csr_wdata = 32'h0;
        #1;
        check("ro_write_illegal", {31'b0, bus.csr_illegal}, 32'h1);
        bus.csr_raddr = 12'h340;
        #1;
        check("ro_write_other_raddr", {31'b0, bus.csr_illegal}, 32'h0);
        tick();
        bus.csr_write = 1'b0;
        rd(12'h301); check("misa_unchanged", bus.csr_rdata, P_MISA);

        wr(12'h305, 32'h0000_0102);
        rd(12'h305); check("mtvec_mode2", bus.csr_rdata, 32'h0000_0100);
        wr(12'h305, 32'h0000_0101);
        wr(12'h300, 32'h0000_0008);
        rd(12'h300); check("mstatus_mie", bus.csr_rdata, 32'h0000_1808);

        // Interrupt trap through the vectored table
        bus.trap_valid  = 1'b1;
        bus.trap_is_irq = 1'b0;
        bus.trap_cause  = 5'd7;
        bus.trap_pc     = 32'h0000_0083;
        bus.trap_tval   = 32'h0000_1234;
        #1;
        check("vector_exc", bus.trap_vector, 32'h0000_0100);
        bus.trap_is_irq = 1'b1;
        #1;
        check("vector_irq", bus.trap_vector, 32'h0000_011C);
        tick();
        bus.trap_valid  = 1'b0;
        bus.trap_is_irq = 1'b0;
        rd(12'h341); check("trap_mepc", bus.csr_rdata, 32'h0000_0080);
        check("trap_mepc_out", bus.mepc_out, 32'h0000_0080);
        rd(12'h342); check("trap_mcause", bus.csr_rdata, 32'h8000_0007);
        rd(12'h343); check("trap_mtval", bus.csr_rdata, 32'h0000_1234);
        rd(12'h300); check("trap_mstatus", bus.csr_rdata, 32'h0000_1880);

        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        rd(12'h300); check("mret_mstatus", bus.csr_rdata, 32'h0000_1888);

        // Trap, mret and mstatus write together: trap wins
        bus.trap_valid = 1'b1;
        bus.trap_cause = 5'd2;
        bus.trap_pc    = 32'h0000_0200;
        bus.trap_tval  = 32'h0000_0BAD;
        bus.mret       = 1'b1;
        wr(12'h300, 32'h0);
        bus.trap_valid = 1'b0;
        bus.mret       = 1'b0;
        rd(12'h300); check("prio_mstatus", bus.csr_rdata, 32'h0000_1880);
        rd(12'h342); check("prio_mcause", bus.csr_rdata, 32'h0000_0002);
        rd(12'h341); check("prio_mepc", bus.csr_rdata, 32'h0000_0200);

        // Trap alongside writes: mscratch lands, mepc write is dropped
        bus.trap_valid = 1'b1;
        bus.trap_cause = 5'd3;
        bus.trap_pc    = 32'h0000_0300;
        wr(12'h340, 32'h0000_0055);
        bus.csr_write  = 1'b1;
        bus.csr_waddr  = 12'h341;
        bus.csr_wdata  = 32'h0000_0F00;
        bus.trap_pc    = 32'h0000_0400;
        tick();
        bus.csr_write  = 1'b0;
        bus.trap_valid = 1'b0;
        rd(12'h340); check("trap_mscratch_lands", bus.csr_rdata, 32'h0000_0055);
        rd(12'h341); check("trap_mepc_wins", bus.csr_rdata, 32'h0000_0400);

        // Interrupt pending gating
        wr(12'h304, 32'h0000_0080);
        bus.irq_tmr = 1'b1;
        wr(12'h300, 32'h0);
        check("irq_masked_mie0", {31'b0, bus.irq_pending}, 32'h0);
        rd(12'h344); check("mip_tmr", bus.csr_rdata, 32'h0000_0080);
        wr(12'h300, 32'h0000_0008);
        check("irq_pending", {31'b0, bus.irq_pending}, 32'h1);
        bus.irq_tmr = 1'b0;
        bus.irq_ext = 1'b1;
        #1;
        check("irq_ext_not_enabled", {31'b0, bus.irq_pending}, 32'h0);
        bus.irq_ext = 1'b0;

`ifdef CSR_COUNTERS_EN
        wr(12'hB00, 32'hFFFF_FFFF);
        bus.csr_write = 1'b1;
        bus.csr_waddr = 12'hB80;
        bus.csr_wdata = 32'hFFFF_FFFF;
        tick();
        bus.csr_write = 1'b0;
        rd(12'hB00); check("mcycle_lo_max", bus.csr_rdata, 32'hFFFF_FFFF);
        rd(12'hB80); check("mcycle_hi_max", bus.csr_rdata, 32'hFFFF_FFFF);
        tick();
        rd(12'hB00); check("mcycle_wrap_lo", bus.csr_rdata, 32'h0);
        rd(12'hC80); check("cycleh_wrap", bus.csr_rdata, 32'h0);

        bus.instr_retire = 1'b1;
        repeat (3) tick();
        bus.instr_retire = 1'b0;
        rd(12'hB02); check("minstret", bus.csr_rdata, 32'd3);
        rd(12'hC02); check("instret_shadow", bus.csr_rdata, 32'd3);

        bus.csr_raddr = 12'hC00;
        bus.csr_write = 1'b1;
        bus.csr_waddr = 12'hC00;
        bus.csr_wdata = 32'h0;
        #1;
        check("shadow_write_illegal", {31'b0, bus.csr_illegal}, 32'h1);
        tick();
        bus.csr_write = 1'b0;
        repeat (3) tick();
`else
        rd(12'hB00); check("nocnt_rdata", bus.csr_rdata, 32'h0);
        check("nocnt_legal", {31'b0, bus.csr_illegal}, 32'h0);
        bus.csr_write = 1'b1;
        bus.csr_waddr = 12'hB00;
        bus.csr_wdata = 32'h0000_0005;
        #1;
        check("nocnt_write_legal", {31'b0, bus.csr_illegal}, 32'h0);
        tick();
        bus.csr_write = 1'b0;
        rd(12'hB00); check("nocnt_write_ignored", bus.csr_rdata, 32'h0);
`endif

        // Asynchronous reset mid-run
        bus.irq_tmr = 1'b1;
        #2;
        nRST = 1'b0;
        #1;
        check("arst_mepc_out", bus.mepc_out, 32'h0);
        check("arst_trap_vector", bus.trap_vector, 32'h0000_1000);
        check("arst_irq_pending", {31'b0, bus.irq_pending}, 32'h0);
        rd(12'h340); check("arst_mscratch", bus.csr_rdata, 32'h0);
`ifdef CSR_COUNTERS_EN
        rd(12'hB00); check("arst_mcycle", bus.csr_rdata, 32'h0);
        rd(12'hB02); check("arst_minstret", bus.csr_rdata, 32'h0);
`endif
        bus.irq_tmr = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
